// File: rtl/rad_cdc_mcp_pkg.sv
// Shared definitions for the multi-cycle-path (MCP) CDC sender.
// Holds the READY/BUSY state type and the toggle-to-pulse helper.
package rad_cdc_mcp_pkg;

    typedef enum logic [0:0] {
        READY = 1'b0,
        BUSY  = 1'b1
    } send_state_e;

    // A toggle handshake signals an event on either edge of the level.
    function automatic logic toggle_seen(input logic level_now, input logic level_prev);
        return level_now ^ level_prev;
    endfunction

endpackage

// File: rtl/rad_cdc_mcp_asend_fsm.sv
// READY/BUSY controller for the MCP sender, with busy-cycle watchdog counter
// and sticky timeout / spurious-ack flags.
module rad_cdc_mcp_asend_fsm
    import rad_cdc_mcp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic send,
    input  logic ack,
    output logic ready,
    output logic accept,
    output logic timeout,
    output logic spurious
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT_CYCLES - 1);

    send_state_e   state;
    logic [CW-1:0] busy_cnt;

    assign ready  = (state == READY);
    assign accept = send && ready;

    // State, watchdog counter and sticky flags; the flag sets on the edge the counter reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= READY;
            busy_cnt <= '0;
            timeout  <= 1'b0;
            spurious <= 1'b0;
        end else begin
            case (state)
                READY: begin
                    if (ack) begin
                        spurious <= 1'b1;
                    end
                    if (send) begin
                        state    <= BUSY;
                        busy_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (busy_cnt != CNT_MAX) begin
                        busy_cnt <= busy_cnt + CW'(1);
                    end
                    if (busy_cnt >= CNT_PRE) begin
                        timeout <= 1'b1;
                    end
                    // A request arriving with the ack is dropped, not accepted.
                    if (ack) begin
                        state <= READY;
                    end
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

endmodule

// File: rtl/rad_cdc_mcp_amcp_send.sv
// Sending side of an MCP formulation CDC with toggle-based enable and ack.
// Holds the data bus, the enable toggle and the ack edge detector.
module rad_cdc_mcp_amcp_send
    import rad_cdc_mcp_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic [WIDTH-1:0] adatain,
    input  logic             asend,
    output logic             aready,
    output logic [WIDTH-1:0] adata,
    output logic             a_en,
    input  logic             aq2_ack,
    output logic             a_timeout,
    output logic             a_spurious
);

    logic ack_q;
    logic a_ack;
    logic accept;

    assign a_ack = toggle_seen(aq2_ack, ack_q);

    rad_cdc_mcp_asend_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk      (aclk),
        .rst      (arst),
        .send     (asend),
        .ack      (a_ack),
        .ready    (aready),
        .accept   (accept),
        .timeout  (a_timeout),
        .spurious (a_spurious)
    );

    // Data is only captured on acceptance so it stays stable for the whole transfer and after.
    always_ff @(posedge aclk) begin
        if (arst) begin
            adata <= '0;
            a_en  <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            ack_q <= aq2_ack;
            if (accept) begin
                adata <= adatain;
                a_en  <= ~a_en;
            end else begin
                adata <= adata;
                a_en  <= a_en;
            end
        end
    end

endmodule

// File: tb/tb_rad_cdc_mcp_amcp_send.sv
// Self-checking bench for rad_cdc_mcp_amcp_send: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_rad_cdc_mcp_amcp_send;

    localparam int W = 8;
    localparam int T = 4;

    logic         aclk = 1'b0;
    logic         arst = 1'b1;
    logic [W-1:0] adatain = '0;
    logic         asend = 1'b0;
    logic         aready;
    logic [W-1:0] adata;
    logic         a_en;
    logic         aq2_ack = 1'b0;
    logic         a_timeout;
    logic         a_spurious;

    int checks = 0;
    int failures = 0;

    rad_cdc_mcp_amcp_send #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .aclk       (aclk),
        .arst       (arst),
        .adatain    (adatain),
        .asend      (asend),
        .aready     (aready),
        .adata      (adata),
        .a_en       (a_en),
        .aq2_ack    (aq2_ack),
        .a_timeout  (a_timeout),
        .a_spurious (a_spurious)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic         rst;
        logic         send;
        logic [W-1:0] din;
        logic         tog;
        logic         e_ready;
        logic [W-1:0] e_adata;
        logic         e_en;
        logic         e_to;
        logic         e_sp;
    } vec_t;

    vec_t vecs[8];

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic r, input logic s, input logic [W-1:0] d, input logic tog);
        @(negedge aclk);
        arst    = r;
        asend   = s;
        adatain = d;
        if (r) aq2_ack = 1'b0;
        else if (tog) aq2_ack = ~aq2_ack;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic r, input logic [W-1:0] d,
                           input logic e, input logic to, input logic sp);
        checks++;
        if (aready !== r || adata !== d || a_en !== e || a_timeout !== to || a_spurious !== sp) begin
            failures++;
            $display("FAIL %s: got rdy=%b data=%02h en=%b to=%b sp=%b expected rdy=%b data=%02h en=%b to=%b sp=%b",
                     name, aready, adata, a_en, a_timeout, a_spurious, r, d, e, to, sp);
        end
    endtask

    // Reference model state
    logic         m_busy;
    logic [W-1:0] m_data;
    int           m_accepts;
    int           m_busy_cyc;
    logic         m_to, m_sp, m_ack_prev;

    initial begin
        //             rst   send  din    tog   rdy   adata  en    to    sp
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].rst, vecs[i].send, vecs[i].din, vecs[i].tog);
            chk_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_adata,
                    vecs[i].e_en, vecs[i].e_to, vecs[i].e_sp);
        end

        // Timeout: no ack for T busy cycles, then a late ack still returns to READY.
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        chk_all("to_accept", 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < T; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("to_pre%0d", k), {31'd0, a_timeout}, 32'd0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("to_set", {31'd0, a_timeout}, 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("to_still_busy", {31'd0, aready}, 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk_all("to_late_ack", 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);

        // Reset mid-BUSY, then a fresh send.
        step(1'b0, 1'b1, 8'h77, 1'b0);
        chk_all("rst_pre", 1'b0, 8'h77, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h99, 1'b1);
        chk_all("rst_mid_busy", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b0);
        chk_all("rst_resend", 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);

        // Randomized run against the reference model.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        m_busy = 1'b0; m_data = '0; m_accepts = 0; m_busy_cyc = 0;
        m_to = 1'b0; m_sp = 1'b0; m_ack_prev = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic r, s, tg, ack;
            logic [W-1:0] d;
            r  = ($urandom_range(0, 99) == 0);
            s  = $urandom_range(0, 1) == 1;
            tg = ($urandom_range(0, 6) == 0);
            d  = W'($urandom);
            step(r, s, d, tg);
            if (r) begin
                m_busy = 1'b0; m_data = '0; m_accepts = 0; m_busy_cyc = 0;
                m_to = 1'b0; m_sp = 1'b0;
            end else begin
                ack = (aq2_ack != m_ack_prev);
                if (!m_busy) begin
                    if (ack) m_sp = 1'b1;
                    if (s) begin
                        m_busy = 1'b1; m_data = d; m_accepts++; m_busy_cyc = 0;
                    end
                end else begin
                    m_busy_cyc++;
                    if (m_busy_cyc >= T) m_to = 1'b1;
                    if (ack) m_busy = 1'b0;
                end
            end
            m_ack_prev = aq2_ack;
            chk_all($sformatf("rand%0d", n), !m_busy, m_data, m_accepts[0], m_to, m_sp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
